// File: rtl/dcache_refill_ctl.sv
// -----------------------------------------------------------------------------
// dcache_refill_ctl
//
// Miss-handling controller for the set-associative data cache. On a miss it
// freezes the pipeline, writes a dirty victim line back to backing memory one
// word at a time, refills the missed line one word at a time, then pulses
// o_fill_done so the cache can install tag/valid and clear dirty. It owns the
// single data-side backing-memory port.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   i_cache_miss    : cache reports a miss on the current access (level)
//   i_miss_addr     : byte address of the missing access
//   i_evict_dirty   : victim line is valid and dirty (writeback needed)
//   i_evict_addr    : any byte address inside the victim line
//   i_evict_data    : victim word selected by o_evict_idx (combinational read)
//   o_evict_idx     : victim word index being written back
//   o_mem_req/we    : memory request valid / 1 = write, 0 = read
//   o_mem_addr      : word-aligned memory address
//   o_mem_wdata     : memory write data
//   i_mem_ack       : memory accepts the write or returns read data this cycle
//   i_mem_rdata     : memory read data, valid with i_mem_ack during a read
//   o_fill_we/idx/data : refill write into the cache line
//   o_fill_done     : one-cycle pulse, line complete
//   o_stall         : freezes PC and all pipeline registers
// -----------------------------------------------------------------------------
module dcache_refill_ctl #(
    parameter int WORDS_PER_LINE = 16,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_cache_miss,
    input  logic [ADDR_W-1:0]                 i_miss_addr,
    input  logic                              i_evict_dirty,
    input  logic [ADDR_W-1:0]                 i_evict_addr,
    input  logic [DATA_W-1:0]                 i_evict_data,
    output logic [$clog2(WORDS_PER_LINE)-1:0] o_evict_idx,
    output logic                              o_mem_req,
    output logic                              o_mem_we,
    output logic [ADDR_W-1:0]                 o_mem_addr,
    output logic [DATA_W-1:0]                 o_mem_wdata,
    input  logic                              i_mem_ack,
    input  logic [DATA_W-1:0]                 i_mem_rdata,
    output logic                              o_fill_we,
    output logic [$clog2(WORDS_PER_LINE)-1:0] o_fill_idx,
    output logic [DATA_W-1:0]                 o_fill_data,
    output logic                              o_fill_done,
    output logic                              o_stall
);

    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int OFF_W = IDX_W + 2;   // byte offset bits within a line

    // Clears the in-line byte offset, leaving the line base.
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic [IDX_W-1:0]    cnt_q,        cnt_d;
    logic [ADDR_W-1:0]   miss_base_q,  miss_base_d;
    logic [ADDR_W-1:0]   evict_base_q, evict_base_d;

    // Byte offset of the current word. Bases have their offset bits cleared,
    // so OR-ing the offset in equals base + 4*cnt and can never carry out of
    // the line.
    logic [ADDR_W-1:0]   word_off;
    assign word_off = ADDR_W'({cnt_q, 2'b00});

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            miss_base_q  <= '0;
            evict_base_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miss_base_q  <= miss_base_d;
            evict_base_q <= evict_base_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        miss_base_d  = miss_base_q;
        evict_base_d = evict_base_q;

        o_evict_idx  = '0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_fill_we    = 1'b0;
        o_fill_idx   = '0;
        o_fill_data  = '0;
        o_fill_done  = 1'b0;

        // Stall in the very cycle the miss is seen, before the FSM moves.
        o_stall      = (state_q != S_IDLE) | i_cache_miss;

        case (state_q)
            S_IDLE: begin
                // i_mem_ack is deliberately ignored here: no request is out.
                if (i_cache_miss) begin
                    miss_base_d  = i_miss_addr  & LINE_MASK;
                    evict_base_d = i_evict_addr & LINE_MASK;
                    cnt_d        = '0;
                    state_d      = i_evict_dirty ? S_WB : S_FILL;
                end
            end

            S_WB: begin
                // Request fields depend only on registered state, so they
                // stay stable until the memory acks.
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = evict_base_q | word_off;
                o_mem_wdata = i_evict_data;
                o_evict_idx = cnt_q;
                if (i_mem_ack) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end else begin
                        cnt_d   = cnt_q + IDX_W'(1);
                    end
                end
            end

            S_FILL: begin
                o_mem_req  = 1'b1;
                o_mem_we   = 1'b0;
                o_mem_addr = miss_base_q | word_off;
                if (i_mem_ack) begin
                    // Read data is forwarded into the line in the ack cycle.
                    o_fill_we   = 1'b1;
                    o_fill_idx  = cnt_q;
                    o_fill_data = i_mem_rdata;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + IDX_W'(1);
                    end
                end
            end

            S_DONE: begin
                o_fill_done = 1'b1;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_refill_ctl.sv
// -----------------------------------------------------------------------------
// tb_dcache_refill_ctl
//
// Self-checking bench for dcache_refill_ctl. The bench acts as both the cache
// (victim data source) and the backing memory (ack policy, read data). Each
// started miss pushes its expected memory transactions onto a scoreboard
// queue; every acked request pops and compares one entry.
// -----------------------------------------------------------------------------
module tb_dcache_refill_ctl;

    localparam int WPL    = 16;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IDX_W  = $clog2(WPL);

    logic              clk = 1'b0;
    logic              rst;
    logic              i_cache_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              i_evict_dirty;
    logic [ADDR_W-1:0] i_evict_addr;
    logic [DATA_W-1:0] i_evict_data;
    logic [IDX_W-1:0]  o_evict_idx;
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              i_mem_ack;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_fill_we;
    logic [IDX_W-1:0]  o_fill_idx;
    logic [DATA_W-1:0] o_fill_data;
    logic              o_fill_done;
    logic              o_stall;

    dcache_refill_ctl #(
        .WORDS_PER_LINE (WPL),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_cache_miss  (i_cache_miss),
        .i_miss_addr   (i_miss_addr),
        .i_evict_dirty (i_evict_dirty),
        .i_evict_addr  (i_evict_addr),
        .i_evict_data  (i_evict_data),
        .o_evict_idx   (o_evict_idx),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata),
        .o_fill_we     (o_fill_we),
        .o_fill_idx    (o_fill_idx),
        .o_fill_data   (o_fill_data),
        .o_fill_done   (o_fill_done),
        .o_stall       (o_stall)
    );

    always #5 clk = ~clk;

    // Cache model: victim word k holds E000_0000 + k.
    assign i_evict_data = 32'hE000_0000 + 32'(o_evict_idx);

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
    } txn_t;

    txn_t sb[$];
    int   done_left_q[$];

    int checks     = 0;
    int failures   = 0;
    int stall_cnt  = 0;
    int done_cnt   = 0;
    int pop_cnt    = 0;
    int ack_cnt    = 0;
    int ack_period = 1;
    bit force_ack  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected transactions for one whole line: writes carry victim data,
    // reads carry the memory model's data for that word.
    task automatic push_line(input bit we, input logic [ADDR_W-1:0] any_addr);
        txn_t t;
        logic [ADDR_W-1:0] base;
        base = any_addr & ~ADDR_W'(WPL * 4 - 1);
        for (int k = 0; k < WPL; k++) begin
            t.we   = we;
            t.addr = base + ADDR_W'(4 * k);
            t.data = (we ? 32'hE000_0000 : 32'hA000_0000) + 32'(k);
            t.idx  = IDX_W'(k);
            sb.push_back(t);
        end
    endtask

    // Memory model and monitor. Ack/rdata are driven at the falling edge,
    // outputs are sampled 1 ns later, well away from the rising edge.
    always @(negedge clk) begin
        txn_t t;
        if (force_ack) begin
            i_mem_ack = 1'b1;
        end else if (o_mem_req) begin
            ack_cnt++;
            i_mem_ack = ((ack_cnt % ack_period) == 0);
        end else begin
            i_mem_ack = 1'b0;
        end
        i_mem_rdata = 32'hA000_0000 + 32'(o_mem_addr[IDX_W+1:2]);
        #1;
        if (o_stall) stall_cnt++;
        if (o_fill_done) begin
            done_cnt++;
            done_left_q.push_back(sb.size());
            check("done_no_req", o_mem_req, 0);
        end
        if (o_mem_req && i_mem_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_req", 1, 0);
            end else begin
                t = sb.pop_front();
                pop_cnt++;
                check("mem_we", o_mem_we, t.we);
                check("mem_addr", o_mem_addr, t.addr);
                if (t.we) begin
                    check("mem_wdata", o_mem_wdata, t.data);
                    check("evict_idx", o_evict_idx, t.idx);
                    check("fill_we_in_wb", o_fill_we, 0);
                end else begin
                    check("fill_we", o_fill_we, 1);
                    check("fill_idx", o_fill_idx, t.idx);
                    check("fill_data", o_fill_data, t.data);
                end
            end
        end else begin
            check("fill_we_no_ack", o_fill_we, 0);
            if (o_mem_req && sb.size() > 0) begin
                check("hold_addr", o_mem_addr, sb[0].addr);
                check("hold_we", o_mem_we, sb[0].we);
            end
        end
    end

    task automatic clear_counters(input int period);
        ack_period = period;
        ack_cnt    = 0;
        stall_cnt  = 0;
        done_cnt   = 0;
        pop_cnt    = 0;
        done_left_q.delete();
    endtask

    task automatic wait_done(input int n, input string tag);
        for (int i = 0; i < 400 && done_cnt < n; i++) tick();
        check({tag, "_done_seen"}, done_cnt, n);
    endtask

    task automatic run_miss(input string tag, input logic [ADDR_W-1:0] maddr,
                            input bit dirty, input logic [ADDR_W-1:0] eaddr,
                            input int period, input int exp_stall);
        tick();
        clear_counters(period);
        if (dirty) push_line(1'b1, eaddr);
        push_line(1'b0, maddr);
        i_cache_miss  = 1'b1;
        i_miss_addr   = maddr;
        i_evict_dirty = dirty;
        i_evict_addr  = eaddr;
        tick();
        // Garbage on the miss-side inputs must be ignored outside IDLE.
        i_cache_miss  = 1'b0;
        i_miss_addr   = 32'hDEAD_BEEF;
        i_evict_dirty = 1'b1;
        i_evict_addr  = 32'h5555_0000;
        wait_done(1, tag);
        tick();
        tick();
        i_evict_dirty = 1'b0;
        check({tag, "_stall_cycles"}, stall_cnt, exp_stall);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        if (done_left_q.size() > 0)
            check({tag, "_left_at_done"}, done_left_q[0], 0);
    endtask

    initial begin
        rst           = 1'b1;
        i_cache_miss  = 1'b0;
        i_miss_addr   = '0;
        i_evict_dirty = 1'b0;
        i_evict_addr  = '0;
        i_mem_ack     = 1'b0;
        i_mem_rdata   = '0;
        #1;
        check("rst_mem_req", o_mem_req, 0);
        check("rst_fill_we", o_fill_we, 0);
        check("rst_fill_done", o_fill_done, 0);
        check("rst_stall", o_stall, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_evict_idx", o_evict_idx, 0);
        i_cache_miss = 1'b1;
        #1;
        check("rst_stall_comb", o_stall, 1);
        i_cache_miss = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Clean miss, zero-wait memory.
        run_miss("clean", 32'h0000_1234, 1'b0, 32'h0000_0000, 1, 18);

        // Dirty miss: writeback then refill.
        run_miss("dirty", 32'h0000_0080, 1'b1, 32'h0000_8040, 1, 34);

        // Memory acks every third cycle.
        run_miss("slow", 32'h0000_4400, 1'b0, 32'h0000_0000, 3, 50);

        // Asynchronous reset in the middle of writeback.
        tick();
        clear_counters(1);
        push_line(1'b1, 32'h0000_8040);
        push_line(1'b0, 32'h0000_0080);
        i_cache_miss  = 1'b1;
        i_miss_addr   = 32'h0000_0080;
        i_evict_dirty = 1'b1;
        i_evict_addr  = 32'h0000_8040;
        tick();
        i_cache_miss  = 1'b0;
        i_evict_dirty = 1'b0;
        for (int i = 0; i < 100 && pop_cnt < 5; i++) tick();
        check("rst_mid_wb_acks", pop_cnt, 5);
        rst = 1'b1;
        sb.delete();
        #1;
        check("rst_mid_mem_req", o_mem_req, 0);
        check("rst_mid_stall", o_stall, 0);
        check("rst_mid_evict_idx", o_evict_idx, 0);
        tick();
        check("rst_mid_req_held", o_mem_req, 0);
        rst = 1'b0;
        run_miss("restart", 32'h0000_0080, 1'b1, 32'h0000_8040, 1, 34);

        // Miss held through DONE; address changes during FILL are ignored,
        // and the second sequence starts only after o_fill_done.
        tick();
        clear_counters(1);
        push_line(1'b0, 32'h0000_1000);
        push_line(1'b0, 32'h0000_2000);
        i_cache_miss = 1'b1;
        i_miss_addr  = 32'h0000_1004;
        repeat (5) tick();
        i_miss_addr  = 32'h0000_2010;
        i_cache_miss = 1'b0;
        tick();
        i_cache_miss = 1'b1;
        wait_done(1, "held1");
        if (done_left_q.size() > 0)
            check("held1_left_at_done", done_left_q[0], WPL);
        tick();
        i_cache_miss = 1'b0;
        wait_done(2, "held2");
        tick();
        tick();
        check("held_stall_cycles", stall_cnt, 36);
        check("held_sb_empty", sb.size(), 0);
        if (done_left_q.size() > 1)
            check("held2_left_at_done", done_left_q[1], 0);

        // Spurious acks while idle must not move the word counter.
        tick();
        force_ack = 1'b1;
        repeat (4) tick();
        check("idle_ack_req", o_mem_req, 0);
        check("idle_ack_done", o_fill_done, 0);
        check("idle_ack_stall", o_stall, 0);
        force_ack = 1'b0;
        run_miss("after_idle_ack", 32'h0000_0040, 1'b0, 32'h0000_0000, 1, 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
